// File: rtl/spec_load_controller_if.sv
// Load request/prediction and d-cache response bundle between the MEM stage
// and the speculative load controller.
interface spec_load_controller_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  ld_req_valid;
  logic [ADDR_WIDTH-1:0] ld_req_pc;
  logic                  ld_req_ready;
  logic                  pred_valid;
  logic [DATA_WIDTH-1:0] pred_data;
  logic                  ld_resp_valid;
  logic [DATA_WIDTH-1:0] ld_resp_data;

  modport master (
    output ld_req_valid, ld_req_pc, ld_resp_valid, ld_resp_data,
    input  ld_req_ready, pred_valid, pred_data
  );

  modport slave (
    input  ld_req_valid, ld_req_pc, ld_resp_valid, ld_resp_data,
    output ld_req_ready, pred_valid, pred_data
  );
endinterface

// File: rtl/spec_load_controller.sv
// Last-value load predictor with per-entry confidence and an in-order FIFO of
// up to MAX_SPEC speculative loads, verified oldest-first as responses return.
module spec_load_controller #(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned ADDR_WIDTH  = 32,
  parameter  int unsigned TABLE_DEPTH = 64,
  parameter  int unsigned CONF_BITS   = 2,
  parameter  int unsigned CONF_THRESH = 2,
  parameter  int unsigned MAX_SPEC    = 4,
  localparam int unsigned CNT_W       = $clog2(MAX_SPEC + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  spec_load_controller_if.slave    bus,
  output logic                     snapshot_take,
  output logic                     recover,
  output logic                     flush_all,
  input  logic                     recover_done,
  output logic                     stall_req,
  output logic [CNT_W-1:0]         spec_count,
  output logic [31:0]              pred_cnt,
  output logic [31:0]              mispred_cnt,
  output logic                     protocol_err
);
  localparam int unsigned IDX_W = $clog2(TABLE_DEPTH);

  typedef enum logic {RUN, RECOVER} state_t;

  typedef struct packed {
    logic                  pred;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] value;
  } ent_t;

  state_t                r_state;
  ent_t                  r_fifo [MAX_SPEC];
  logic [CNT_W-1:0]      r_count;
  logic                  r_valid [TABLE_DEPTH];
  logic [CONF_BITS-1:0]  r_conf  [TABLE_DEPTH];
  logic [DATA_WIDTH-1:0] r_value [TABLE_DEPTH];
  logic [31:0]           r_pred_cnt;
  logic [31:0]           r_mispred_cnt;
  logic                  r_protocol_err;

  logic             w_full, w_blocking, w_has_pred, w_ready;
  logic             w_accept, w_push, w_pop, w_predict, w_mispred;
  logic [IDX_W-1:0] w_req_idx;
  ent_t             w_head, w_new;
  logic [CNT_W-1:0] w_wr_ptr;
  logic             w_unused;

  assign w_unused = ^{bus.ld_req_pc[ADDR_WIDTH-1:IDX_W+2], bus.ld_req_pc[1:0]};

  always_comb begin
    w_blocking = 1'b0;
    w_has_pred = 1'b0;
    for (int unsigned i = 0; i < MAX_SPEC; i++) begin
      if (CNT_W'(i) < r_count) begin
        if (r_fifo[i].pred) w_has_pred = 1'b1;
        else                w_blocking = 1'b1;
      end
    end
    w_full    = (r_count == CNT_W'(MAX_SPEC));
    w_ready   = (r_state == RUN) && !w_full && !w_blocking;
    w_req_idx = bus.ld_req_pc[IDX_W+1:2];
    w_head    = r_fifo[0];
    w_pop     = bus.ld_resp_valid && (r_count != '0);
    w_mispred = w_pop && w_head.pred && (w_head.value != bus.ld_resp_data);
    w_accept  = bus.ld_req_valid && w_ready;
    // A mispredict squashes the whole FIFO, including a load accepted this cycle.
    w_push    = w_accept && !w_mispred;
    w_predict = w_push && r_valid[w_req_idx] &&
                (32'(r_conf[w_req_idx]) >= CONF_THRESH);
    w_wr_ptr  = w_pop ? r_count - CNT_W'(1) : r_count;
    w_new.pred  = w_predict;
    w_new.idx   = w_req_idx;
    w_new.value = r_value[w_req_idx];
  end

  assign bus.ld_req_ready = w_ready;
  assign bus.pred_valid   = w_predict;
  assign bus.pred_data    = w_predict ? r_value[w_req_idx] : '0;
  assign snapshot_take    = w_predict && !w_has_pred;
  assign recover          = w_mispred;
  assign flush_all        = (r_state == RECOVER);
  assign stall_req        = (r_state != RUN) || w_full || w_blocking;
  assign spec_count       = r_count;
  assign pred_cnt         = r_pred_cnt;
  assign mispred_cnt      = r_mispred_cnt;
  assign protocol_err     = r_protocol_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_count        <= '0;
      r_pred_cnt     <= '0;
      r_mispred_cnt  <= '0;
      r_protocol_err <= 1'b0;
      for (int unsigned i = 0; i < MAX_SPEC; i++) r_fifo[i] <= '0;
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_conf[i]  <= '0;
        r_value[i] <= '0;
      end
    end else begin
      case (r_state)
        RUN:     if (w_mispred)    r_state <= RECOVER;
        RECOVER: if (recover_done) r_state <= RUN;
        default:                   r_state <= RUN;
      endcase

      if (bus.ld_resp_valid && (r_count == '0)) r_protocol_err <= 1'b1;
      if (w_predict && (r_pred_cnt != '1))      r_pred_cnt     <= r_pred_cnt + 32'd1;
      if (w_mispred && (r_mispred_cnt != '1))   r_mispred_cnt  <= r_mispred_cnt + 32'd1;

      if (w_mispred) begin
        r_count <= '0;
      end else begin
        // Pop shifts the queue down; a same-cycle push lands in the freed slot.
        for (int unsigned i = 0; i < MAX_SPEC; i++) begin
          if (w_push && (CNT_W'(i) == w_wr_ptr))
            r_fifo[i] <= w_new;
          else if (w_pop && (i + 1 < MAX_SPEC))
            r_fifo[i] <= r_fifo[(i + 1) % MAX_SPEC];
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end

      if (w_pop) begin
        if (w_head.pred && !w_mispred) begin
          if (r_conf[w_head.idx] != '1)
            r_conf[w_head.idx] <= r_conf[w_head.idx] + CONF_BITS'(1);
        end else if (!w_head.pred && r_valid[w_head.idx] &&
                     (r_value[w_head.idx] == bus.ld_resp_data)) begin
          if (r_conf[w_head.idx] != '1)
            r_conf[w_head.idx] <= r_conf[w_head.idx] + CONF_BITS'(1);
        end else begin
          r_valid[w_head.idx] <= 1'b1;
          r_value[w_head.idx] <= bus.ld_resp_data;
          r_conf[w_head.idx]  <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spec_load_controller.sv
// Self-checking bench for spec_load_controller: cycle vector table with a
// scoreboard queue, then hand-written protocol-error and async-reset sequences.
module tb_spec_load_controller;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int NV = 23;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        recover_done = 1'b0;
  logic        snapshot_take, recover, flush_all, stall_req, protocol_err;
  logic [2:0]  spec_count;
  logic [31:0] pred_cnt, mispred_cnt;

  spec_load_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  spec_load_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TABLE_DEPTH(64),
    .CONF_BITS(2), .CONF_THRESH(2), .MAX_SPEC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .snapshot_take(snapshot_take), .recover(recover), .flush_all(flush_all),
    .recover_done(recover_done), .stall_req(stall_req), .spec_count(spec_count),
    .pred_cnt(pred_cnt), .mispred_cnt(mispred_cnt), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld; logic [31:0] pc; logic rsp; logic [31:0] rd; logic rdone;
    logic ready; logic pv; logic [31:0] pd; logic snap; logic rec;
    logic fl; logic st; logic [2:0] cnt;
  } vec_t;

  typedef struct {
    logic ready; logic pv; logic [31:0] pd; logic snap; logic rec; logic fl; logic st;
  } exp_t;

  vec_t vecs [NV];
  exp_t sbq [$];
  int   n_checks = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic ld, logic [31:0] pc, logic rsp, logic [31:0] rd,
                              logic rdone, logic ready, logic pv, logic [31:0] pd,
                              logic snap, logic rec, logic fl, logic st, logic [2:0] cnt);
    vec_t v;
    v.ld = ld; v.pc = pc; v.rsp = rsp; v.rd = rd; v.rdone = rdone;
    v.ready = ready; v.pv = pv; v.pd = pd; v.snap = snap; v.rec = rec;
    v.fl = fl; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic ld, input logic [31:0] pc, input logic rsp,
                        input logic [31:0] rd, input logic rdone);
    bus.ld_req_valid  = ld;
    bus.ld_req_pc     = pc;
    bus.ld_resp_valid = rsp;
    bus.ld_resp_data  = rd;
    recover_done      = rdone;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    //                ld  pc          rsp rd     rdn rdy pv pd     snp rec fl st cnt
    vecs[0]  = mk(1, 32'h400, 0, 0,     0, 1, 0, 0,     0, 0, 0, 0, 1);
    vecs[1]  = mk(0, 32'h400, 1, 8'hAB, 0, 0, 0, 0,     0, 0, 0, 1, 0);
    vecs[2]  = mk(1, 32'h400, 0, 0,     0, 1, 0, 0,     0, 0, 0, 0, 1);
    vecs[3]  = mk(0, 32'h400, 1, 8'hAB, 0, 0, 0, 0,     0, 0, 0, 1, 0);
    vecs[4]  = mk(1, 32'h400, 0, 0,     0, 1, 0, 0,     0, 0, 0, 0, 1);
    vecs[5]  = mk(0, 32'h400, 1, 8'hAB, 0, 0, 0, 0,     0, 0, 0, 1, 0);
    vecs[6]  = mk(1, 32'h400, 0, 0,     0, 1, 1, 8'hAB, 1, 0, 0, 0, 1);
    vecs[7]  = mk(1, 32'h400, 0, 0,     0, 1, 1, 8'hAB, 0, 0, 0, 0, 2);
    vecs[8]  = mk(1, 32'h400, 0, 0,     0, 1, 1, 8'hAB, 0, 0, 0, 0, 3);
    vecs[9]  = mk(1, 32'h400, 0, 0,     0, 1, 1, 8'hAB, 0, 0, 0, 0, 4);
    vecs[10] = mk(1, 32'h400, 0, 0,     0, 0, 0, 0,     0, 0, 0, 1, 4);
    vecs[11] = mk(0, 32'h400, 1, 8'hAB, 0, 0, 0, 0,     0, 0, 0, 1, 3);
    vecs[12] = mk(0, 32'h400, 0, 0,     0, 1, 0, 0,     0, 0, 0, 0, 3);
    vecs[13] = mk(0, 32'h400, 1, 8'hAB, 0, 1, 0, 0,     0, 0, 0, 0, 2);
    vecs[14] = mk(1, 32'h400, 1, 8'hAB, 0, 1, 1, 8'hAB, 0, 0, 0, 0, 2);
    vecs[15] = mk(0, 32'h400, 1, 8'hAB, 0, 1, 0, 0,     0, 0, 0, 0, 1);
    vecs[16] = mk(0, 32'h400, 1, 8'hAB, 0, 1, 0, 0,     0, 0, 0, 0, 0);
    vecs[17] = mk(1, 32'h400, 0, 0,     0, 1, 1, 8'hAB, 1, 0, 0, 0, 1);
    vecs[18] = mk(1, 32'h400, 1, 8'hCD, 0, 1, 0, 0,     0, 1, 0, 0, 0);
    vecs[19] = mk(0, 32'h400, 0, 0,     0, 0, 0, 0,     0, 0, 1, 1, 0);
    vecs[20] = mk(0, 32'h400, 0, 0,     1, 0, 0, 0,     0, 0, 1, 1, 0);
    vecs[21] = mk(1, 32'h400, 0, 0,     0, 1, 0, 0,     0, 0, 0, 0, 1);
    vecs[22] = mk(0, 32'h400, 1, 8'hCD, 0, 0, 0, 0,     0, 0, 0, 1, 0);

    set_in(0, '0, 0, '0, 0);
    #12;
    chk("rst_spec_count", 32'(spec_count), 0);
    chk("rst_pred_cnt", pred_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    chk("rst_protocol_err", 32'(protocol_err), 0);
    chk("rst_flush_all", 32'(flush_all), 0);
    chk("rst_stall_req", 32'(stall_req), 0);
    chk("rst_ready", 32'(bus.ld_req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].ld, vecs[i].pc, vecs[i].rsp, vecs[i].rd, vecs[i].rdone);
      e.ready = vecs[i].ready; e.pv = vecs[i].pv; e.pd = vecs[i].pd;
      e.snap = vecs[i].snap; e.rec = vecs[i].rec; e.fl = vecs[i].fl; e.st = vecs[i].st;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("v%0d_ready", i), 32'(bus.ld_req_ready), 32'(e.ready));
      chk($sformatf("v%0d_pred_valid", i), 32'(bus.pred_valid), 32'(e.pv));
      chk($sformatf("v%0d_pred_data", i), bus.pred_data, e.pd);
      chk($sformatf("v%0d_snapshot", i), 32'(snapshot_take), 32'(e.snap));
      chk($sformatf("v%0d_recover", i), 32'(recover), 32'(e.rec));
      chk($sformatf("v%0d_flush_all", i), 32'(flush_all), 32'(e.fl));
      chk($sformatf("v%0d_stall_req", i), 32'(stall_req), 32'(e.st));
      cyc();
      chk($sformatf("v%0d_spec_count", i), 32'(spec_count), 32'(vecs[i].cnt));
    end
    set_in(0, '0, 0, '0, 0);
    chk("tbl_pred_cnt", pred_cnt, 6);
    chk("tbl_mispred_cnt", mispred_cnt, 1);
    chk("tbl_protocol_err", 32'(protocol_err), 0);

    // Response with an empty FIFO: ignored, sticky error.
    set_in(0, '0, 1, 32'h55, 0);
    cyc();
    set_in(0, '0, 0, '0, 0);
    chk("perr_set", 32'(protocol_err), 1);
    chk("perr_count", 32'(spec_count), 0);
    cyc();
    chk("perr_sticky", 32'(protocol_err), 1);

    // Train pc 0x1004 to confidence 2, then mispredict and reset mid-RECOVER.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 32'h1004, 0, '0, 0);
      cyc();
      set_in(0, 32'h1004, 1, 32'h11, 0);
      cyc();
    end
    set_in(1, 32'h1004, 0, '0, 0);
    @(negedge clk);
    chk("seq_pred_valid", 32'(bus.pred_valid), 1);
    chk("seq_pred_data", bus.pred_data, 32'h11);
    chk("seq_snapshot", 32'(snapshot_take), 1);
    cyc();
    set_in(0, 32'h1004, 1, 32'h22, 0);
    @(negedge clk);
    chk("seq_recover", 32'(recover), 1);
    cyc();
    set_in(0, '0, 0, '0, 0);
    chk("seq_recover_pulse_end", 32'(recover), 0);
    chk("seq_flush_all", 32'(flush_all), 1);
    chk("seq_mispred_cnt", mispred_cnt, 2);
    chk("seq_pred_cnt", pred_cnt, 7);
    chk("seq_spec_count", 32'(spec_count), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flush_all", 32'(flush_all), 0);
    chk("arst_stall_req", 32'(stall_req), 0);
    chk("arst_ready", 32'(bus.ld_req_ready), 1);
    chk("arst_pred_cnt", pred_cnt, 0);
    chk("arst_mispred_cnt", mispred_cnt, 0);
    chk("arst_protocol_err", 32'(protocol_err), 0);
    chk("arst_spec_count", 32'(spec_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    set_in(1, 32'h1004, 0, '0, 0);
    @(negedge clk);
    chk("post_rst_pred_valid", 32'(bus.pred_valid), 0);
    chk("post_rst_snapshot", 32'(snapshot_take), 0);
    cyc();
    set_in(0, '0, 0, '0, 0);
    chk("post_rst_spec_count", 32'(spec_count), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
